ident_match_ctrl: RTL

- Sequential wrapper around an 8-bit identity compare. It holds a loadable reference byte, samples a strobed bus byte, and registers the compare result as an active-low match.
- Counts matches and raises a held interrupt request after a programmable number of hits, cleared by an acknowledge handshake.
- Used for bus-address watch and breakpoint logic feeding the interrupt and control section.

---
 rtl/ident_match_pkg.sv | 16 +
 rtl/ident_cmp8.sv | 16 +
 rtl/ident_match_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ident_match_pkg.sv
// ident_match_pkg
// Shared definitions for the identity-match watch block:
//   - state_t : controller state encoding (IDLE / ARMED / TRIGGERED)
//   - DEF_THRESH, DEF_CNT_W : default trigger threshold and hit counter width
package ident_match_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2
  } state_t;

  localparam int DEF_THRESH = 1;
  localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/ident_cmp8.sv
// ident_cmp8
// Combinational masked 8-bit identity compare.
// Ports:
//   a, b  : bytes being compared
//   mask  : 1 = bit participates, 0 = don't-care
//   eq    : 1 when every participating bit of a equals b (always 1 when mask is 0)
module ident_cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] mask,
  output logic       eq
);

  assign eq = (((a ^ b) & mask) == 8'h00);

endmodule

// File: rtl/ident_match_ctrl.sv
// ident_match_ctrl
// Holds a loadable reference byte, compares strobed bus bytes against it under
// a mask, registers an active-low match flag, counts hits while armed and
// raises a held IRQ once the hit count reaches the threshold.
// Ports:
//   sysclk, sys_rst : clock (rising edge) and asynchronous active-high reset
//   DIN_7_0, LOAD   : reference value and its load pulse
//   ARM             : IDLE -> ARMED pulse
//   BUS_7_0, MASK_7_0, STROBE : byte under test, compare mask, byte valid
//   ACK             : interrupt acknowledge
//   MATCH_n         : registered match, active low
//   IRQ             : interrupt request, held until ACK
//   HITS            : current hit count
//   STATE_1_0       : 0 IDLE, 1 ARMED, 2 TRIGGERED
//   REF_7_0         : reference register readback
module ident_match_ctrl
  import ident_match_pkg::*;
#(
  parameter int THRESH     = DEF_THRESH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CONSEC     = 0,
  parameter int AUTO_REARM = 1
) (
  input  logic             sysclk,
  input  logic             sys_rst,
  input  logic [7:0]       DIN_7_0,
  input  logic             LOAD,
  input  logic             ARM,
  input  logic [7:0]       BUS_7_0,
  input  logic [7:0]       MASK_7_0,
  input  logic             STROBE,
  input  logic             ACK,
  output logic             MATCH_n,
  output logic             IRQ,
  output logic [CNT_W-1:0] HITS,
  output logic [1:0]       STATE_1_0,
  output logic [7:0]       REF_7_0
);

  // A threshold of 0 would trigger without any hit; treat it as 1.
  localparam int               EFF_THRESH = (THRESH < 1) ? 1 : THRESH;
  localparam logic [CNT_W:0]   THRESH_W   = EFF_THRESH[CNT_W:0];
  localparam logic [CNT_W-1:0] HITS_MAX   = '1;

  state_t           state_reg, state_next;
  logic [7:0]       ref_reg, ref_next;
  logic [CNT_W-1:0] hits_reg, hits_next;
  logic [CNT_W-1:0] hits_inc;
  logic             irq_reg, irq_next;
  logic             match_n_reg, match_n_next;
  logic             eq;

  // Compare always uses the currently held reference, so a same-cycle LOAD
  // only affects strobes from the following cycle on.
  ident_cmp8 u_cmp (
    .a    (BUS_7_0),
    .b    (ref_reg),
    .mask (MASK_7_0),
    .eq   (eq)
  );

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg   <= S_IDLE;
      ref_reg     <= 8'h00;
      hits_reg    <= '0;
      irq_reg     <= 1'b0;
      match_n_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      ref_reg     <= ref_next;
      hits_reg    <= hits_next;
      irq_reg     <= irq_next;
      match_n_reg <= match_n_next;
    end
  end

  // Saturating increment so the counter never wraps back below threshold.
  assign hits_inc = (hits_reg == HITS_MAX) ? hits_reg : hits_reg + CNT_W'(1);

  always_comb begin
    state_next   = state_reg;
    ref_next     = ref_reg;
    hits_next    = hits_reg;
    irq_next     = irq_reg;
    // Match flag is independent of the controller state.
    match_n_next = ~(STROBE & eq);

    if (LOAD) begin
      // Loading a new reference restarts the watch from scratch and
      // overrides ARM, ACK and counting in the same cycle.
      ref_next   = DIN_7_0;
      hits_next  = '0;
      irq_next   = 1'b0;
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (ARM) begin
            state_next = S_ARMED;
          end
        end
        S_ARMED: begin
          // ACK is not looked at here, so a triggering strobe still wins.
          if (STROBE) begin
            if (eq) begin
              hits_next = hits_inc;
              if ({1'b0, hits_inc} >= THRESH_W) begin
                state_next = S_TRIG;
                irq_next   = 1'b1;
              end
            end else if (CONSEC != 0) begin
              hits_next = '0;
            end
          end
        end
        S_TRIG: begin
          if (ACK) begin
            irq_next   = 1'b0;
            hits_next  = '0;
            state_next = (AUTO_REARM != 0) ? S_ARMED : S_IDLE;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean idle state.
          state_next = S_IDLE;
          hits_next  = '0;
          irq_next   = 1'b0;
        end
      endcase
    end
  end

  assign MATCH_n   = match_n_reg;
  assign IRQ       = irq_reg;
  assign HITS      = hits_reg;
  assign STATE_1_0 = state_reg;
  assign REF_7_0   = ref_reg;

endmodule
